ram_buffer_ctrl: RTL and testbench
==================================

// Module: ram_buffer_ctrl
// PURPOSE
//  Sequencer and allocator for the ENT_NUM-entry RAM read buffer that feeds the MXU.
//  Accepts one read request at a time and looks it up against the entry tags.
//  On a hit it re-arms the matching entry; on a miss it fetches the 128-bit line from RAM and allocates a free entry.
//  It then watches that entry drain its bytes and releases the entry's reference.
// PARAMETERS
//  ENT_NUM        16    number of buffer entries (power of 2, >=2)
//  ENT_IDX_W      4     log2(ENT_NUM)
//  DRAIN_TO_CYC   32    max DRAIN cycles before err_timeout
// PORTS
//  clk              in   1         clock, rising edge
//  rst_n            in   1         async active-low reset
//  req_vld          in   1         read request valid
//  req_rdy          out  1         request accepted when vld&rdy
//  req_addr         in   8         line address
//  req_start_byte   in   4         first byte to stream
//  req_end_byte     in   4         last byte to stream
//  ent_tag_match    in   ENT_NUM   per-entry tag==req_addr_q (entry holds data, valid or not)
//  ent_vld          in   ENT_NUM   per-entry draining flag
//  ent_free         in   ENT_NUM   per-entry ref count == 0
//  ram_rd_vld       out  1         RAM fetch request
//  ram_rd_rdy       in   1         RAM accepts fetch
//  ram_rd_addr      out  8         fetch address
//  ram_rsp_vld      in   1         fetch data valid (1-cycle pulse)
//  ram_rsp_data     in   128       fetch data
//  alloc_en         out  ENT_NUM   one-hot: load data/tag, start drain
//  alloc_addr       out  8         tag for alloc
//  alloc_data       out  128       data for alloc
//  ent_rearm        out  ENT_NUM   one-hot: restart drain without data load (hit)
//  buff_start_byte  out  4         start byte for armed entry
//  buff_end_byte    out  4         end byte for armed entry
//  ent_cnt_inc      out  ENT_NUM   one-hot ref-count increment
//  ent_cnt_dec      out  ENT_NUM   one-hot ref-count decrement
//  busy             out  1         state != IDLE
//  err_timeout      out  1         1-cycle pulse, drain exceeded DRAIN_TO_CYC
// BEHAVIOUR
//  Reset: state=IDLE, req_rdy=1, every pulse/one-hot output=0, rr_ptr=0, data/tag regs=0.
//  FSM: IDLE -> LOOKUP -> {ARM | FETCH_REQ -> FETCH_WAIT -> ALLOC} -> DRAIN -> IDLE.
//   IDLE: req_rdy=1. On req_vld: capture addr/start/end; go to LOOKUP.
//   LOOKUP (1 cyc): a hit is any ent_tag_match bit set; the lowest index wins.
//    On a hit, latch tgt and go to ARM. On a miss, go to FETCH_REQ.
//   ARM (1 cyc): ent_rearm[tgt]=1, ent_cnt_inc[tgt]=1, buff_*_byte=captured; ->DRAIN.
//   FETCH_REQ: ram_rd_vld=1 and ram_rd_addr=captured addr, held until ram_rd_rdy.
//    Leave for FETCH_WAIT on the handshake.
//   FETCH_WAIT: on ram_rsp_vld, latch data; ->ALLOC.
//   ALLOC: victim = first ent_free bit scanning upward from rr_ptr, with wrap.
//    If none is free, stay in ALLOC; the data is held and there is no timeout.
//    Otherwise drive for 1 cycle: alloc_en[v], alloc_addr, alloc_data, buff_*_byte.
//    Entry alloc sets its count to 1; ent_cnt_inc is not asserted.
//    Then tgt=v, rr_ptr=v+1 mod ENT_NUM; ->DRAIN.
//   DRAIN: skip the first cycle, so that ent_vld registers.
//    Then wait for ent_vld[tgt]==0, pulse ent_cnt_dec[tgt], and go to IDLE.
//    Cycle counter >= DRAIN_TO_CYC: pulse err_timeout and ent_cnt_dec[tgt]; ->IDLE.
//  buff_start_byte/buff_end_byte stay stable from ARM/ALLOC through DRAIN.
//   The entry uses them for direction each cycle.
//  start==end is legal and gives a single-byte drain.
//  Never assert alloc_en|ent_rearm and ent_cnt_dec to the same entry in one cycle.
//  A hit has priority over a miss, even when the matching entry is free.
//  The ENT_NUM-bit one-hot outputs are zero outside their cycle.
//  Async reset mid-fetch drops the outstanding RAM response.
//   The RAM side is reset by the same rst_n.
//  Latency:
//   hit: req handshake -> ent_rearm = 2 cycles.
//   miss: ram_rsp_vld -> alloc_en = 1 cycle.
// STRUCTURE
//  ram_buffer_defines.vh: ENT_NUM, ENT_IDX_W, state encodings
//   (IDLE, LOOKUP, ARM, FETCH_REQ, FETCH_WAIT, ALLOC, DRAIN), byte-index width.
//  Sub-module ram_buffer_victim_sel: rotating-priority finder.
//   Inputs: ENT_NUM mask and rr_ptr. Outputs: one-hot grant, index, found flag.
//  Hit priority encoding is inline. The FSM and drain counter use DFFR/DFFRE.
// TESTING
//  1 Miss to empty buffer: req addr=0x10, start=0, end=15.
//    -> one ram_rd handshake; alloc_en[0] 1 cycle after rsp.
//    -> ent_cnt_dec[0] after ent_vld[0] falls; busy returns to 0.
//  2 Hit: ent_tag_match=0x0004, start=15, end=8.
//    -> ent_rearm[2]+ent_cnt_inc[2] 2 cycles after handshake.
//    -> buff bytes 15/8; no ram_rd_vld.
//  3 Round-robin: ent 0..15 free, rr_ptr=14, miss.
//    -> alloc_en[14], rr_ptr=15; next miss alloc_en[15], then alloc_en[0] (wrap).
//  4 Full: ent_free=0 during ALLOC for 10 cycles, then ent_free[5]=1.
//    -> alloc_en[5] same cycle, alloc_data equals held rsp data.
//  5 Backpressure/timeout: ram_rd_rdy low 20 cycles.
//    -> ram_rd_vld/addr stable, req_rdy=0.
//    ent_vld[tgt] stuck 1 -> err_timeout at 32 cycles, dec pulse, IDLE.
//  6 rst_n low in FETCH_WAIT -> all outputs at reset values; later rsp ignored.

Source files
------------

// File: rtl/ram_buffer_ctrl_pkg.sv
// Shared sizes, state encoding and helpers for the MXU RAM read-buffer controller.
package ram_buffer_ctrl_pkg;

  localparam int ENT_NUM      = 16;
  localparam int ENT_IDX_W    = 4;
  localparam int DRAIN_TO_CYC = 32;
  localparam int ADDR_W       = 8;
  localparam int BYTE_W       = 4;
  localparam int LINE_W       = 128;
  localparam int DRAIN_CNT_W  = $clog2(DRAIN_TO_CYC + 1);

  localparam logic [DRAIN_CNT_W-1:0] DRAIN_TO_LIM = DRAIN_CNT_W'(DRAIN_TO_CYC);
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_ONE    = {{(DRAIN_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ENT_IDX_W-1:0]   IDX_ONE      = {{(ENT_IDX_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOOKUP     = 3'd1,
    ST_ARM        = 3'd2,
    ST_FETCH_REQ  = 3'd3,
    ST_FETCH_WAIT = 3'd4,
    ST_ALLOC      = 3'd5,
    ST_DRAIN      = 3'd6
  } state_e;

  function automatic logic [ENT_NUM-1:0] idx_to_onehot(input logic [ENT_IDX_W-1:0] idx);
    return {{(ENT_NUM-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/ram_buffer_ctrl_if.sv
// Request and RAM-fetch handshake bundle of the read-buffer controller.
interface ram_buffer_ctrl_if;
  import ram_buffer_ctrl_pkg::*;

  logic              req_vld;
  logic              req_rdy;
  logic [ADDR_W-1:0] req_addr;
  logic [BYTE_W-1:0] req_start_byte;
  logic [BYTE_W-1:0] req_end_byte;
  logic              ram_rd_vld;
  logic              ram_rd_rdy;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic              ram_rsp_vld;
  logic [LINE_W-1:0] ram_rsp_data;

  modport master (
    output req_vld, req_addr, req_start_byte, req_end_byte,
    output ram_rd_rdy, ram_rsp_vld, ram_rsp_data,
    input  req_rdy, ram_rd_vld, ram_rd_addr
  );

  modport slave (
    input  req_vld, req_addr, req_start_byte, req_end_byte,
    input  ram_rd_rdy, ram_rsp_vld, ram_rsp_data,
    output req_rdy, ram_rd_vld, ram_rd_addr
  );

endinterface

// File: rtl/ram_buffer_ctrl_victim_sel.sv
// Rotating-priority finder: first set mask bit at or above rr_ptr, wrapping around.
module ram_buffer_victim_sel
  import ram_buffer_ctrl_pkg::*;
(
  input  logic [ENT_NUM-1:0]   mask,
  input  logic [ENT_IDX_W-1:0] rr_ptr,
  output logic [ENT_NUM-1:0]   grant,
  output logic [ENT_IDX_W-1:0] idx,
  output logic                 found
);

  logic [ENT_IDX_W-1:0] cand_s;
  logic [ENT_IDX_W-1:0] idx_s;
  logic                 found_s;

  // Scan upward from rr_ptr; index arithmetic wraps naturally at ENT_NUM
  always_comb begin
    found_s = 1'b0;
    idx_s   = '0;
    cand_s  = rr_ptr;
    for (int k = 0; k < ENT_NUM; k++) begin
      cand_s = rr_ptr + ENT_IDX_W'(k);
      if (!found_s && mask[cand_s]) begin
        found_s = 1'b1;
        idx_s   = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign found = found_s;
  assign idx   = idx_s;
  assign grant = found_s ? idx_to_onehot(idx_s) : '0;

endmodule

// File: rtl/ram_buffer_ctrl.sv
// Sequencer/allocator for the MXU RAM read buffer: tag lookup, fetch on miss,
// entry arm/alloc, then drain supervision with timeout.
module ram_buffer_ctrl
  import ram_buffer_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  ram_buffer_ctrl_if.slave    bus,
  input  logic [ENT_NUM-1:0]  ent_tag_match,
  input  logic [ENT_NUM-1:0]  ent_vld,
  input  logic [ENT_NUM-1:0]  ent_free,
  output logic [ENT_NUM-1:0]  alloc_en,
  output logic [ADDR_W-1:0]   alloc_addr,
  output logic [LINE_W-1:0]   alloc_data,
  output logic [ENT_NUM-1:0]  ent_rearm,
  output logic [BYTE_W-1:0]   buff_start_byte,
  output logic [BYTE_W-1:0]   buff_end_byte,
  output logic [ENT_NUM-1:0]  ent_cnt_inc,
  output logic [ENT_NUM-1:0]  ent_cnt_dec,
  output logic                busy,
  output logic                err_timeout
);

  state_e                 state_r;
  logic [ADDR_W-1:0]      addr_r;
  logic [BYTE_W-1:0]      start_r;
  logic [BYTE_W-1:0]      end_r;
  logic [LINE_W-1:0]      data_r;
  logic [ENT_IDX_W-1:0]   tgt_r;
  logic [ENT_IDX_W-1:0]   rr_ptr_r;
  logic [DRAIN_CNT_W-1:0] drain_cnt_r;
  logic                   req_rdy_r;
  logic                   rd_vld_r;
  logic                   busy_r;
  logic [ENT_NUM-1:0]     rearm_r;
  logic [ENT_NUM-1:0]     inc_r;
  logic [ENT_NUM-1:0]     dec_r;
  logic                   err_r;

  logic                   hit_s;
  logic [ENT_IDX_W-1:0]   hit_idx_s;
  logic [ENT_NUM-1:0]     vic_grant_s;
  logic [ENT_IDX_W-1:0]   vic_idx_s;
  logic                   vic_found_s;

  // Lowest-index tag hit; a matching entry wins even if it is also free
  always_comb begin
    hit_s     = |ent_tag_match;
    hit_idx_s = '0;
    for (int i = ENT_NUM - 1; i >= 0; i--) begin
      if (ent_tag_match[i]) begin
        hit_idx_s = ENT_IDX_W'(i);
      end else begin
        hit_idx_s = hit_idx_s;
      end
    end
  end

  ram_buffer_victim_sel u_victim_sel (
    .mask   (ent_free),
    .rr_ptr (rr_ptr_r),
    .grant  (vic_grant_s),
    .idx    (vic_idx_s),
    .found  (vic_found_s)
  );

  // Request FSM, capture registers and drain watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      addr_r      <= '0;
      start_r     <= '0;
      end_r       <= '0;
      data_r      <= '0;
      tgt_r       <= '0;
      rr_ptr_r    <= '0;
      drain_cnt_r <= '0;
      req_rdy_r   <= 1'b1;
      rd_vld_r    <= 1'b0;
      busy_r      <= 1'b0;
      rearm_r     <= '0;
      inc_r       <= '0;
      dec_r       <= '0;
      err_r       <= 1'b0;
    end else begin
      rearm_r <= '0;
      inc_r   <= '0;
      dec_r   <= '0;
      err_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.req_vld && req_rdy_r) begin
            addr_r    <= bus.req_addr;
            start_r   <= bus.req_start_byte;
            end_r     <= bus.req_end_byte;
            req_rdy_r <= 1'b0;
            busy_r    <= 1'b1;
            state_r   <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (hit_s) begin
            tgt_r   <= hit_idx_s;
            rearm_r <= idx_to_onehot(hit_idx_s);
            inc_r   <= idx_to_onehot(hit_idx_s);
            state_r <= ST_ARM;
          end else begin
            rd_vld_r <= 1'b1;
            state_r  <= ST_FETCH_REQ;
          end
        end
        ST_ARM: begin
          drain_cnt_r <= '0;
          state_r     <= ST_DRAIN;
        end
        ST_FETCH_REQ: begin
          if (bus.ram_rd_rdy) begin
            rd_vld_r <= 1'b0;
            state_r  <= ST_FETCH_WAIT;
          end
        end
        ST_FETCH_WAIT: begin
          if (bus.ram_rsp_vld) begin
            data_r  <= bus.ram_rsp_data;
            state_r <= ST_ALLOC;
          end
        end
        // Waits here indefinitely with the line held until some entry frees up
        ST_ALLOC: begin
          if (vic_found_s) begin
            tgt_r       <= vic_idx_s;
            rr_ptr_r    <= vic_idx_s + IDX_ONE;
            drain_cnt_r <= '0;
            state_r     <= ST_DRAIN;
          end
        end
        // First cycle is skipped so the entry's own ent_vld has registered
        ST_DRAIN: begin
          if (drain_cnt_r == '0) begin
            drain_cnt_r <= drain_cnt_r + DRAIN_ONE;
          end else if (!ent_vld[tgt_r] || (drain_cnt_r >= DRAIN_TO_LIM)) begin
            dec_r     <= idx_to_onehot(tgt_r);
            err_r     <= ent_vld[tgt_r];
            req_rdy_r <= 1'b1;
            busy_r    <= 1'b0;
            state_r   <= ST_IDLE;
          end else begin
            drain_cnt_r <= drain_cnt_r + DRAIN_ONE;
          end
        end
        default: begin
          req_rdy_r <= 1'b1;
          rd_vld_r  <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_rdy     = req_rdy_r;
  assign bus.ram_rd_vld  = rd_vld_r;
  assign bus.ram_rd_addr = addr_r;

  assign alloc_en        = (state_r == ST_ALLOC) ? vic_grant_s : '0;
  assign alloc_addr      = addr_r;
  assign alloc_data      = data_r;
  assign ent_rearm       = rearm_r;
  assign ent_cnt_inc     = inc_r;
  assign ent_cnt_dec     = dec_r;
  assign buff_start_byte = start_r;
  assign buff_end_byte   = end_r;
  assign busy            = busy_r;
  assign err_timeout     = err_r;

endmodule

// File: tb/tb_ram_buffer_ctrl.sv
// Self-checking bench for ram_buffer_ctrl: directed table, corner sequences and
// random transactions against a transaction-level reference model.
module tb_ram_buffer_ctrl;
  import ram_buffer_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ram_buffer_ctrl_if bus ();

  logic [15:0]  ent_tag_match, ent_vld, ent_free;
  logic [15:0]  alloc_en, ent_rearm, ent_cnt_inc, ent_cnt_dec;
  logic [7:0]   alloc_addr;
  logic [127:0] alloc_data;
  logic [3:0]   buff_start_byte, buff_end_byte;
  logic         busy, err_timeout;

  ram_buffer_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .ent_tag_match   (ent_tag_match),
    .ent_vld         (ent_vld),
    .ent_free        (ent_free),
    .alloc_en        (alloc_en),
    .alloc_addr      (alloc_addr),
    .alloc_data      (alloc_data),
    .ent_rearm       (ent_rearm),
    .buff_start_byte (buff_start_byte),
    .buff_end_byte   (buff_end_byte),
    .ent_cnt_inc     (ent_cnt_inc),
    .ent_cnt_dec     (ent_cnt_dec),
    .busy            (busy),
    .err_timeout     (err_timeout)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [3:0]  sb;
    logic [3:0]  eb;
    logic [15:0] tm;
    logic [15:0] free;
    int          free_hold;
    int          rdy_dly;
    int          rsp_dly;
    int          drain_len;
    logic        exp_hit;
    int          exp_tgt;
    logic        exp_err;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int model_rr = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] a, input logic [3:0] sb, input logic [3:0] eb,
                              input logic [15:0] tm, input logic [15:0] fr, input int fh,
                              input int rd, input int rs, input int dl,
                              input logic hit, input int tgt, input logic er);
    vec_t v;
    v.addr = a; v.sb = sb; v.eb = eb; v.tm = tm; v.free = fr;
    v.free_hold = fh; v.rdy_dly = rd; v.rsp_dly = rs; v.drain_len = dl;
    v.exp_hit = hit; v.exp_tgt = tgt; v.exp_err = er;
    return v;
  endfunction

  // Reference: lowest matching tag wins; else first free entry from the rr pointer, wrapping
  function automatic int model_tgt(input logic [15:0] tm, input logic [15:0] fr, input int rr);
    if (tm != 16'h0) begin
      for (int i = 0; i < 16; i++) if (tm[i]) return i;
    end
    for (int k = 0; k < 16; k++) if (fr[(rr + k) % 16]) return (rr + k) % 16;
    return -1;
  endfunction

  function automatic logic [15:0] bit_of(input int i);
    return 16'h0001 << i;
  endfunction

  task automatic drive_idle();
    bus.req_vld = 1'b0; bus.req_addr = 8'h00; bus.req_start_byte = 4'h0; bus.req_end_byte = 4'h0;
    bus.ram_rd_rdy = 1'b0; bus.ram_rsp_vld = 1'b0; bus.ram_rsp_data = 128'h0;
    ent_tag_match = 16'h0; ent_vld = 16'h0; ent_free = 16'h0;
  endtask

  // One full request, with the bench acting as RAM and buffer entries
  task automatic do_txn(input vec_t v, input logic [127:0] data);
    bit hs_done = 0, done = 0, overlap = 0, unstable = 0, stray_inc = 0, moved = 0;
    bit prev_wait = 0;
    int hs_c = -1000, rd_vld_cnt = 0, rd_hs_n = 0, rd_hs_c = -1000, rsp_c = -1000;
    int act_c = -1000, tgt_obs = -1, dec_n = 0, dec_c = -1000, err_n = 0, err_c = -1000;
    logic [15:0]  arm_vec = 16'h0, inc_vec = 16'h0, alloc_vec = 16'h0, dec_vec = 16'h0, exp_vec;
    logic [7:0]   rd_addr = 8'h00, al_addr = 8'h00, prev_addr = 8'h00;
    logic [127:0] al_data = 128'h0;
    logic [3:0]   bs = 4'h0, be = 4'h0;
    logic         busy_end = 1'b1;
    for (int c = 0; c < 250 && !done; c++) begin
      @(negedge clk);
      bus.req_vld = !hs_done; bus.req_addr = v.addr;
      bus.req_start_byte = v.sb; bus.req_end_byte = v.eb;
      ent_tag_match = v.tm;
      if (bus.ram_rd_vld) begin
        bus.ram_rd_rdy = (rd_vld_cnt >= v.rdy_dly);
        rd_vld_cnt++;
      end else begin
        bus.ram_rd_rdy = 1'b0;
      end
      bus.ram_rsp_vld  = (c == rd_hs_c + 1 + v.rsp_dly);
      bus.ram_rsp_data = bus.ram_rsp_vld ? data : ~data;
      if (bus.ram_rsp_vld) rsp_c = c;
      ent_free = (c > rsp_c && c <= rsp_c + v.free_hold) ? 16'h0 : v.free;
      ent_vld  = (tgt_obs >= 0 && c > act_c && c <= act_c + v.drain_len) ? bit_of(tgt_obs) : 16'h0;
      #1;
      if (!hs_done && bus.req_vld && bus.req_rdy) begin hs_done = 1; hs_c = c; end
      if (bus.ram_rd_vld && bus.req_rdy) unstable = 1;
      if (prev_wait && (!bus.ram_rd_vld || bus.ram_rd_addr !== prev_addr)) unstable = 1;
      prev_wait = bus.ram_rd_vld && !bus.ram_rd_rdy;
      prev_addr = bus.ram_rd_addr;
      if (bus.ram_rd_vld && bus.ram_rd_rdy) begin rd_hs_n++; rd_hs_c = c; rd_addr = bus.ram_rd_addr; end
      if (ent_rearm != 16'h0 || alloc_en != 16'h0) begin
        arm_vec |= ent_rearm; alloc_vec |= alloc_en; inc_vec |= ent_cnt_inc;
        act_c = c; al_addr = alloc_addr; al_data = alloc_data;
        bs = buff_start_byte; be = buff_end_byte;
        for (int i = 15; i >= 0; i--) if (ent_rearm[i] || alloc_en[i]) tgt_obs = i;
      end else if (ent_cnt_inc != 16'h0) begin
        stray_inc = 1;
      end
      if (act_c >= 0 && dec_n == 0 && (buff_start_byte !== bs || buff_end_byte !== be)) moved = 1;
      if (((ent_rearm | alloc_en) & ent_cnt_dec) != 16'h0) overlap = 1;
      if (ent_cnt_dec != 16'h0) begin dec_vec |= ent_cnt_dec; dec_n++; dec_c = c; end
      if (err_timeout) begin err_n++; err_c = c; end
      if (dec_n > 0 && c > dec_c) begin busy_end = busy; done = 1; end
    end
    drive_idle();
    exp_vec = bit_of(v.exp_tgt);
    check("txn_completes", done, 1);
    check("req_handshake", hs_done, 1);
    if (v.exp_hit) begin
      check("hit_rearm", arm_vec, exp_vec);
      check("hit_cnt_inc", inc_vec, exp_vec);
      check("hit_no_alloc", alloc_vec, 0);
      check("hit_no_ram_rd", rd_hs_n, 0);
      check("hit_latency", act_c - hs_c, 2);
    end else begin
      check("miss_alloc_en", alloc_vec, exp_vec);
      check("miss_no_rearm", arm_vec, 0);
      check("miss_no_inc", inc_vec, 0);
      check("miss_ram_rd_count", rd_hs_n, 1);
      check("miss_ram_rd_addr", rd_addr, v.addr);
      check("miss_alloc_addr", al_addr, v.addr);
      check("miss_alloc_data", al_data, data);
      check("miss_alloc_latency", act_c - rsp_c, 1 + v.free_hold);
    end
    check("buff_start_byte", bs, v.sb);
    check("buff_end_byte", be, v.eb);
    check("buff_bytes_stable", moved, 0);
    check("cnt_dec_vec", dec_vec, exp_vec);
    check("cnt_dec_once", dec_n, 1);
    check("no_arm_dec_overlap", overlap, 0);
    check("fetch_stable_rdy_low", unstable, 0);
    check("no_stray_inc", stray_inc, 0);
    check("busy_idle_after", busy_end, 0);
    check("err_timeout_count", err_n, v.exp_err);
    if (v.exp_err) begin
      check("err_with_dec", err_c, dec_c);
      check("err_timeout_window", (err_c - act_c >= 32) && (err_c - act_c <= 36), 1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_rdy"}, bus.req_rdy, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ram_rd_vld"}, bus.ram_rd_vld, 0);
    check({tag, "_pulses"}, {alloc_en, ent_rearm, ent_cnt_inc, ent_cnt_dec, err_timeout}, 0);
    check({tag, "_alloc_data"}, alloc_data, 0);
    check({tag, "_alloc_addr"}, alloc_addr, 0);
    check({tag, "_buff_bytes"}, {buff_start_byte, buff_end_byte}, 0);
  endtask

  vec_t tbl[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d;
    vec_t v;
    bit stray;
    rst_n = 1'b0;
    drive_idle();
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    tbl[0] = mk(8'h10, 4'd0,  4'd15, 16'h0000, 16'hFFFF, 0, 0, 0, 4, 1'b0, 0,  1'b0);
    tbl[1] = mk(8'h22, 4'd15, 4'd8,  16'h0004, 16'hFFFF, 0, 0, 0, 3, 1'b1, 2,  1'b0);
    tbl[2] = mk(8'h33, 4'd3,  4'd9,  16'h0030, 16'hFFFF, 0, 0, 0, 2, 1'b1, 4,  1'b0);
    tbl[3] = mk(8'h44, 4'd1,  4'd2,  16'h0000, 16'h2000, 0, 1, 2, 2, 1'b0, 13, 1'b0);
    tbl[4] = mk(8'h45, 4'd4,  4'd5,  16'h0000, 16'hFFFF, 0, 0, 1, 1, 1'b0, 14, 1'b0);
    tbl[5] = mk(8'h46, 4'd6,  4'd7,  16'h0000, 16'hFFFF, 0, 2, 0, 2, 1'b0, 15, 1'b0);
    tbl[6] = mk(8'h47, 4'd8,  4'd9,  16'h0000, 16'hFFFF, 0, 0, 0, 3, 1'b0, 0,  1'b0);
    tbl[7] = mk(8'h48, 4'd2,  4'd0,  16'h0000, 16'h0001, 0, 0, 3, 1, 1'b0, 0,  1'b0);
    tbl[8] = mk(8'h49, 4'd7,  4'd7,  16'h8000, 16'h0000, 0, 0, 0, 1, 1'b1, 15, 1'b0);
    tbl[9] = mk(8'h4A, 4'd9,  4'd3,  16'h0000, 16'h0006, 0, 0, 0, 0, 1'b0, 1,  1'b0);
    for (int i = 0; i < 10; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      do_txn(tbl[i], d);
      if (!tbl[i].exp_hit) model_rr = (tbl[i].exp_tgt + 1) % 16;
    end

    // Buffer full for 10 ALLOC cycles, then only entry 5 frees up
    d = {$urandom, $urandom, $urandom, $urandom};
    v = mk(8'h5C, 4'd0, 4'd15, 16'h0000, 16'h0020, 10, 0, 1, 2, 1'b0, 5, 1'b0);
    do_txn(v, d);
    model_rr = 6;

    // RAM backpressure for 20 cycles, then the entry never drains
    d = {$urandom, $urandom, $urandom, $urandom};
    v = mk(8'h77, 4'd2, 4'd12, 16'h0000, 16'hFFFF, 0, 20, 0, 100, 1'b0,
           model_tgt(16'h0, 16'hFFFF, model_rr), 1'b1);
    do_txn(v, d);
    model_rr = (v.exp_tgt + 1) % 16;

    // Reset while waiting for the RAM response; the late response must be ignored
    @(negedge clk);
    bus.req_vld = 1'b1; bus.req_addr = 8'h5A; bus.req_start_byte = 4'd1; bus.req_end_byte = 4'd6;
    ent_free = 16'hFFFF;
    @(negedge clk);
    bus.req_vld = 1'b0;
    bus.ram_rd_rdy = 1'b1;
    for (int c = 0; c < 10 && !(bus.ram_rd_vld && bus.ram_rd_rdy); c++) @(negedge clk);
    check("rst_test_rd_issued", bus.ram_rd_vld, 1);
    @(negedge clk);
    bus.ram_rd_rdy = 1'b0;
    #1;
    check("rst_test_busy_fetch_wait", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midfetch_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.ram_rsp_vld = 1'b1; bus.ram_rsp_data = {4{32'hDEADBEEF}};
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (alloc_en != 16'h0 || busy || bus.ram_rd_vld) stray = 1;
      @(negedge clk);
      bus.ram_rsp_vld = 1'b0;
    end
    check("late_rsp_ignored", stray, 0);
    model_rr = 0;

    d = {$urandom, $urandom, $urandom, $urandom};
    v = mk(8'h81, 4'd3, 4'd3, 16'h0000, 16'hFFFF, 0, 0, 0, 2, 1'b0, 0, 1'b0);
    do_txn(v, d);
    model_rr = 1;

    for (int n = 0; n < 30; n++) begin
      logic [15:0] tm, fr;
      tm = ($urandom_range(0, 1) == 0) ? 16'h0 : (16'($urandom) | bit_of($urandom_range(0, 15)));
      fr = 16'($urandom_range(1, 16'hFFFF));
      v = mk(8'($urandom), 4'($urandom), 4'($urandom), tm, fr,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 6),
             (tm != 16'h0), model_tgt(tm, fr, model_rr), 1'b0);
      d = {$urandom, $urandom, $urandom, $urandom};
      do_txn(v, d);
      if (!v.exp_hit) model_rr = (v.exp_tgt + 1) % 16;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
